// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings shared by bus agents
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic logic size_legal(input logic [2:0] size, input int xlen);
    return (xlen == 64) ? (size <= HSIZE_DWORD) : (size <= HSIZE_WORD);
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - pipelined AHB-Lite initiator, one request stream in, in-order responses out
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int         XLen  = 64,
  parameter logic [3:0] HPROT = 4'b0011
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLen-1:0] req_addr,
  input  logic [2:0]      req_size,
  input  logic [XLen-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLen-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic [1:0]      io_ahb_htrans,
  output logic            io_ahb_hmastlock,
  output logic [XLen-1:0] io_ahb_haddr,
  output logic            io_ahb_hwrite,
  output logic [2:0]      io_ahb_hburst,
  output logic [2:0]      io_ahb_hsize,
  output logic [3:0]      io_ahb_hprot,
  output logic [XLen-1:0] io_ahb_hwdata,
  input  logic [XLen-1:0] io_ahb_hrdata,
  input  logic            io_ahb_hready,
  input  logic            io_ahb_hresp
);

  logic            ap_valid_q, ap_valid_d;
  logic            ap_write_q, ap_write_d;
  logic [XLen-1:0] ap_addr_q,  ap_addr_d;
  logic [2:0]      ap_size_q,  ap_size_d;
  logic [XLen-1:0] ap_wdata_q, ap_wdata_d;

  logic            dp_valid_q, dp_valid_d;
  logic            dp_write_q, dp_write_d;
  logic [XLen-1:0] dp_wdata_q, dp_wdata_d;

  logic            err1_q, err1_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLen-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;

  logic            accept;

  assign req_ready = !reset && !err1_q && (!ap_valid_q || io_ahb_hready);
  assign accept    = req_valid && req_ready;

  // While err1 is set the address-phase request is cancelled, not lost: it is re-presented afterwards.
  assign io_ahb_htrans    = (ap_valid_q && !err1_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign io_ahb_haddr     = ap_addr_q;
  assign io_ahb_hwrite    = ap_write_q;
  assign io_ahb_hsize     = ap_size_q;
  assign io_ahb_hburst    = HBURST_SINGLE;
  assign io_ahb_hprot     = HPROT;
  assign io_ahb_hmastlock = 1'b0;
  assign io_ahb_hwdata    = (dp_valid_q && dp_write_q) ? dp_wdata_q : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  always_comb begin
    ap_valid_d  = ap_valid_q;
    ap_write_d  = ap_write_q;
    ap_addr_d   = ap_addr_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    err1_d      = err1_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    if (io_ahb_hready && dp_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = io_ahb_hresp;
      rsp_rdata_d = dp_write_q ? '0 : io_ahb_hrdata;
    end

    if (err1_q) begin
      if (io_ahb_hready) begin
        err1_d     = 1'b0;
        dp_valid_d = 1'b0;
      end
    end else if (io_ahb_hready) begin
      dp_valid_d = ap_valid_q;
      dp_write_d = ap_write_q;
      dp_wdata_d = ap_wdata_q;
      ap_valid_d = accept;
    end else if (dp_valid_q && io_ahb_hresp == HRESP_ERROR) begin
      err1_d = 1'b1;
    end

    // An empty address slot may be filled even during a data-phase wait state.
    if (accept) begin
      ap_valid_d = 1'b1;
      ap_write_d = req_write;
      ap_addr_d  = req_addr;
      ap_size_d  = req_size;
      ap_wdata_d = req_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ap_valid_q  <= 1'b0;
      ap_write_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_size_q   <= '0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      err1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_write_q  <= ap_write_d;
      ap_addr_q   <= ap_addr_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      err1_q      <= err1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  a_req_size_legal: assert property (@(posedge clock) disable iff (reset)
    req_valid |-> size_legal(req_size, XLen));
  a_htrans_legal: assert property (@(posedge clock) disable iff (reset)
    (io_ahb_htrans == HTRANS_IDLE) || (io_ahb_htrans == HTRANS_NONSEQ));

endmodule
